// File: rtl/shift_pkg.sv
// Shared shift-unit definitions: op encodings and shift-amount width.
package shift_pkg;

  localparam int unsigned SHAMT_W = 4;

  typedef logic [1:0] op_t;

  localparam op_t OP_ROL = 2'b00;
  localparam op_t OP_SLL = 2'b01;
  localparam op_t OP_ROR = 2'b10;
  localparam op_t OP_SRL = 2'b11;

endpackage

// File: rtl/Shifter.sv
// 16-bit combinational barrel shifter: rotate/shift left/right by 0..15.
module Shifter
  import shift_pkg::*;
(
  input  logic [15:0]        src,
  input  logic [SHAMT_W-1:0] amt,
  input  op_t                op,
  output logic [15:0]        result
);

  // Complementary amount for the wrap-around half of a rotate; 16 for amt 0 flushes it to zero.
  logic [4:0] inv_amt;
  assign inv_amt = 5'd16 - {1'b0, amt};

  // Op decode onto the four shift flavours.
  always_comb begin
    result = src;
    case (op)
      OP_ROL: result = (src << amt) | (src >> inv_amt);
      OP_SLL: result = src << amt;
      OP_ROR: result = (src >> amt) | (src << inv_amt);
      OP_SRL: result = src >> amt;
    endcase
  end

endmodule

// File: rtl/ex_shift_unit.sv
// Execute-stage shift unit: two-stage elastic pipeline (operand capture, shift + result slot).
// Optional build macro EX_SHIFT_STATS_EN adds a saturating output-transfer counter (stat_count).
module ex_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_W-1:0]     in_src,
  input  logic [DATA_W-1:0]     in_amt_reg,
  input  logic [SHAMT_W-1:0]    in_imm,
  input  logic                  in_use_imm,
  input  logic [REG_ADDR_W-1:0] in_wr_reg,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_wr_reg,
  output logic                  out_zero
`ifdef EX_SHIFT_STATS_EN
  ,
  output logic [15:0]           stat_count
`endif
);

  logic                  a_valid;
  op_t                   a_op;
  logic [DATA_W-1:0]     a_src;
  logic [SHAMT_W-1:0]    a_amt;
  logic [REG_ADDR_W-1:0] a_wr_reg;
  logic                  b_valid;

  logic                  b_free;
  logic                  a_adv;
  logic                  in_fire;
  logic [DATA_W-1:0]     shift_res;

  // Upper amount bits are architecturally ignored.
  logic unused_amt_hi;
  assign unused_amt_hi = ^in_amt_reg[DATA_W-1:SHAMT_W];

  // Elastic handshake: ready depends only on occupancy and out_ready.
  assign b_free    = !b_valid || out_ready;
  assign a_adv     = a_valid && b_free;
  assign in_ready  = !a_valid || a_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = b_valid;

  // Stage A: capture operands, resolving the amount source at capture time.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid  <= 1'b0;
      a_op     <= OP_ROL;
      a_src    <= '0;
      a_amt    <= '0;
      a_wr_reg <= '0;
    end else if (flush) begin
      a_valid <= 1'b0;
    end else if (in_fire) begin
      a_valid  <= 1'b1;
      a_op     <= in_op;
      a_src    <= in_src;
      a_amt    <= in_use_imm ? in_imm : in_amt_reg[SHAMT_W-1:0];
      a_wr_reg <= in_wr_reg;
    end else if (a_adv) begin
      a_valid <= 1'b0;
    end
  end

  Shifter u_shifter (
    .src    (a_src),
    .amt    (a_amt),
    .op     (a_op),
    .result (shift_res)
  );

  // Stage B: result slot, held stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid    <= 1'b0;
      out_result <= '0;
      out_wr_reg <= '0;
      out_zero   <= 1'b0;
    end else if (flush) begin
      b_valid <= 1'b0;
    end else if (a_adv) begin
      b_valid    <= 1'b1;
      out_result <= shift_res;
      out_wr_reg <= a_wr_reg;
      out_zero   <= (shift_res == '0);
    end else if (out_ready) begin
      b_valid <= 1'b0;
    end
  end

`ifdef EX_SHIFT_STATS_EN
  // Saturating count of output transfers; flush does not touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_count <= '0;
    end else if (out_valid && out_ready && (stat_count != 16'hFFFF)) begin
      stat_count <= stat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_shift_unit.sv
// Self-checking bench for ex_shift_unit: queue scoreboard plus directed literal checks.
module tb_ex_shift_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_src;
  logic [15:0] in_amt_reg;
  logic [3:0]  in_imm;
  logic        in_use_imm;
  logic [2:0]  in_wr_reg;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_wr_reg;
  logic        out_zero;
`ifdef EX_SHIFT_STATS_EN
  logic [15:0] stat_count;
`endif

  ex_shift_unit #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src     (in_src),
    .in_amt_reg (in_amt_reg),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_wr_reg  (in_wr_reg),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_wr_reg (out_wr_reg),
    .out_zero   (out_zero)
`ifdef EX_SHIFT_STATS_EN
    ,
    .stat_count (stat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_count = 0;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  wr;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: apply the op one bit-position at a time, amt times.
  function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] src, input int amt);
    logic [15:0] v;
    v = src;
    for (int i = 0; i < amt; i++) begin
      case (op)
        2'b00: v = {v[14:0], v[15]};
        2'b01: v = {v[14:0], 1'b0};
        2'b10: v = {v[0], v[15:1]};
        default: v = {1'b0, v[15:1]};
      endcase
    end
    return v;
  endfunction

  // Scoreboard: every cycle, check ready, hold and in-order delivery against the pending queue.
  logic hold_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), (q.size() == 2 && !out_ready) ? 32'd0 : 32'd1);
      if (hold_prev) chk("hold_valid", 32'(out_valid), 32'd1);
      if (out_valid) begin
        chk("out_has_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          chk("sb_result", 32'(out_result), 32'(q[0].res));
          chk("sb_wr_reg", 32'(out_wr_reg), 32'(q[0].wr));
          chk("sb_zero", 32'(out_zero), 32'(q[0].res == 16'h0));
          if (out_ready) begin
            void'(q.pop_front());
            out_count++;
          end
        end
      end
      hold_prev = out_valid && !out_ready && !flush;
      if (in_valid && in_ready) begin
        exp_t e;
        e.res = model(in_op, in_src, in_use_imm ? int'(in_imm) : int'(in_amt_reg[3:0]));
        e.wr  = in_wr_reg;
        q.push_back(e);
      end
      if (flush) q.delete();
    end
  end

  // Caller is at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [15:0] src, input logic [15:0] amtr,
                      input logic [3:0] imm, input logic ui, input logic [2:0] wr);
    in_valid   = 1'b1;
    in_op      = op;
    in_src     = src;
    in_amt_reg = amtr;
    in_imm     = imm;
    in_use_imm = ui;
    in_wr_reg  = wr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [15:0] res, input logic zero);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        chk(name, 32'(out_result), 32'(res));
        chk({name, "_zero"}, 32'(out_zero), 32'(zero));
        return;
      end
    end
    chk({name, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_src = '0; in_amt_reg = '0; in_imm = '0; in_use_imm = 1'b0; in_wr_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_wr_reg", 32'(out_wr_reg), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef EX_SHIFT_STATS_EN
    chk("rst_stat", 32'(stat_count), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // ROL by immediate, with latency check.
    send(2'b00, 16'h8001, 16'h0000, 4'd1, 1'b1, 3'd5);
    @(negedge clk);
    chk("rol_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("rol_lat2", 32'(out_valid), 32'd1);
    chk("rol_res", 32'(out_result), 32'h0003);
    chk("rol_zero", 32'(out_zero), 32'd0);
    chk("rol_wr", 32'(out_wr_reg), 32'd5);

    // Register-amount path, immediate is a decoy.
    @(posedge clk); #1;
    send(2'b01, 16'h00FF, 16'hFFF8, 4'd3, 1'b0, 3'd1);
    wait_out("sll_reg", 16'hFF00, 1'b0);
    @(posedge clk); #1;
    send(2'b10, 16'h0001, 16'h0004, 4'hF, 1'b0, 3'd2);
    wait_out("ror_reg", 16'h1000, 1'b0);
    @(posedge clk); #1;
    send(2'b11, 16'h8000, 16'h0000, 4'd15, 1'b1, 3'd3);
    wait_out("srl_15", 16'h0001, 1'b0);
    @(posedge clk); #1;
    send(2'b01, 16'h8000, 16'h0000, 4'd1, 1'b1, 3'd4);
    wait_out("sll_to_zero", 16'h0000, 1'b1);

    // Amount boundaries 0 and 15, back to back, scoreboard-checked.
    @(posedge clk); #1;
    for (int op = 0; op < 4; op++) send(2'(op), 16'hA5C3, 16'h0000, 4'd0, 1'b1, 3'(op));
    for (int op = 0; op < 4; op++) send(2'(op), 16'hA5C3, 16'h123F, 4'd2, 1'b0, 3'(op + 4));
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two accepted, third stalls, result held, then drains in order.
    base = out_count;
    out_ready = 1'b0;
    send(2'b00, 16'h0011, 16'h0000, 4'd4, 1'b1, 3'd1);
    send(2'b01, 16'h0003, 16'h0000, 4'd2, 1'b1, 3'd2);
    in_valid = 1'b1; in_op = 2'b10; in_src = 16'h00F0; in_imm = 4'd4; in_use_imm = 1'b1; in_wr_reg = 3'd3;
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_res", 32'(out_result), 32'h0110);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_hold_res2", 32'(out_result), 32'h0110);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b10, 16'h00F0, 16'h0000, 4'd4, 1'b1, 3'd3);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_drained", 32'(out_count - base), 32'd3);

    // Flush with both stages full; op offered in the flush cycle must vanish.
    out_ready = 1'b0;
    send(2'b01, 16'h0101, 16'h0000, 4'd1, 1'b1, 3'd6);
    send(2'b00, 16'h1234, 16'h0000, 4'd4, 1'b1, 3'd7);
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'b11; in_src = 16'hFFFF; in_imm = 4'd1; in_use_imm = 1'b1; in_wr_reg = 3'd2;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
    end

    // Reset mid-operation clears everything.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2'b00, 16'h00F0, 16'h0000, 4'd1, 1'b1, 3'd7);
    send(2'b01, 16'h0F00, 16'h0000, 4'd1, 1'b1, 3'd6);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_out_result", 32'(out_result), 32'd0);
    chk("rst2_out_wr_reg", 32'(out_wr_reg), 32'd0);
    chk("rst2_out_zero", 32'(out_zero), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst2_stays_empty", 32'(out_valid), 32'd0);

`ifdef EX_SHIFT_STATS_EN
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send(2'b01, 16'(i + 1), 16'h0000, 4'd1, 1'b1, 3'(i));
    repeat (4) @(posedge clk);
    #1;
    chk("stat_five", 32'(stat_count), 32'd5);
    out_ready = 1'b0;
    send(2'b00, 16'h0001, 16'h0000, 4'd1, 1'b1, 3'd1);
    send(2'b00, 16'h0002, 16'h0000, 4'd1, 1'b1, 3'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stat_after_flush", 32'(stat_count), 32'd5);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
